// File: rtl/fu_issue_sched_pkg.sv
// Shared processor defines: CDB source encoding, FU class indices and the
// default multiplier latency used by the issue scheduler.
package fu_issue_sched_pkg;

  localparam int unsigned MULT_LAT_DEF = 4;

  typedef enum logic [1:0] {
    CDB_NONE = 2'd0,
    CDB_ALU  = 2'd1,
    CDB_MEM  = 2'd2,
    CDB_MULT = 2'd3
  } cdb_src_e;

  // Round-robin pointer values; also the bit index of each class in req/gnt.
  typedef enum logic [1:0] {
    CLS_ALU  = 2'd0,
    CLS_MEM  = 2'd1,
    CLS_MULT = 2'd2
  } fu_cls_e;

endpackage

// File: rtl/fu_issue_sched_rr_arb3.sv
// Three-way combinational round-robin pick: first requester at or after ptr
// in the order ALU(0) -> MEM(1) -> MULT(2), one-hot grant out.
module rr_arb3 (
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] gnt
);

  logic [1:0] base;
  logic [5:0] req_dbl;
  logic [2:0] rot;
  logic [2:0] pick;
  logic [5:0] gnt_dbl;

  // Rotate so ptr sits at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    base    = (ptr == 2'd3) ? 2'd0 : ptr;
    req_dbl = {req, req};
    rot     = req_dbl[base +: 3];
    pick    = rot & (~rot + 3'd1);
    gnt_dbl = {pick, pick} << base;
    gnt     = gnt_dbl[5:3];
  end

endmodule

// File: rtl/fu_issue_sched.sv
// Issue scheduler for ALU/MEM/MULT functional units sharing one CDB: picks at
// most one issue per cycle and books CDB slots ahead for the multiplier.
module fu_issue_sched
  import fu_issue_sched_pkg::*;
#(
  parameter int unsigned MULT_LAT = MULT_LAT_DEF,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alu_rdy,
  input  logic             mem_rdy,
  input  logic             mult_rdy,
  input  logic             flush,
  input  logic             mem_wb_req,
  output logic             alu_free,
  output logic             mem_free,
  output logic             mult_free,
  output logic             mem_wb_gnt,
  output logic [1:0]       cdb_sel,
  output logic             mem_busy,
  output logic [CNT_W-1:0] cdb_stall_cnt
);

  logic [MULT_LAT-1:1] resv;
  logic [MULT_LAT-1:0] resv_ext;
  fu_cls_e             rr;
  cdb_src_e            cdb_q;
  logic                issue_ok;
  logic                slot1_taken;
  logic [2:0]          req;
  logic [2:0]          gnt;

  assign issue_ok    = !reset && !flush;
  assign mem_wb_gnt  = mem_wb_req && !resv[1] && issue_ok;
  assign slot1_taken = resv[1] || mem_wb_gnt;
  assign req         = {mult_rdy, mem_rdy && !mem_busy, alu_rdy && !slot1_taken};

  rr_arb3 u_arb (
    .req (req),
    .ptr (rr),
    .gnt (gnt)
  );

  assign alu_free  = gnt[CLS_ALU]  && issue_ok;
  assign mem_free  = gnt[CLS_MEM]  && issue_ok;
  assign mult_free = gnt[CLS_MULT] && issue_ok;
  assign cdb_sel   = cdb_q;

  // Shift toward slot 1 by dropping bit 0 of {new, resv}; valid for MULT_LAT=2 too.
  assign resv_ext = {mult_free, resv};

  always_ff @(posedge clk) begin
    if (reset) begin
      resv          <= '0;
      mem_busy      <= 1'b0;
      rr            <= CLS_ALU;
      cdb_q         <= CDB_NONE;
      cdb_stall_cnt <= '0;
    end else if (flush) begin
      resv     <= '0;
      mem_busy <= 1'b0;
      cdb_q    <= CDB_NONE;
    end else begin
      resv <= resv_ext[MULT_LAT-1:1];
      if (mem_free)
        mem_busy <= 1'b1;
      else if (mem_wb_gnt)
        mem_busy <= 1'b0;
      if (alu_free)
        rr <= CLS_MEM;
      else if (mem_free)
        rr <= CLS_MULT;
      else if (mult_free)
        rr <= CLS_ALU;
      if (resv[1])
        cdb_q <= CDB_MULT;
      else if (mem_wb_gnt)
        cdb_q <= CDB_MEM;
      else if (alu_free)
        cdb_q <= CDB_ALU;
      else
        cdb_q <= CDB_NONE;
      if (alu_rdy && slot1_taken && (cdb_stall_cnt != '1))
        cdb_stall_cnt <= cdb_stall_cnt + CNT_W'(1);
    end
  end

  a_cdb_no_collision: assert property (@(posedge clk) disable iff (reset)
    !(resv[1] && (alu_free || mem_wb_gnt)));

endmodule
